// File: rtl/icache_dm_param.sv
// Direct-mapped instruction cache for the mox125 fetch stage.
// Each lookup returns the halfword at A plus the 32 bits at A+2/A+4. The three
// halfwords may live in two different lines, so each is looked up independently
// and a miss fills the first missing line; IDLE re-evaluates after every fill.
module icache_dm_param #(
    parameter int ADDR_W     = 32,
    parameter int LINES      = 256,
    parameter int LINE_BYTES = 32
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [ADDR_W-1:0] adr_i,
    input  logic              stb_i,
    input  logic              inv_i,
    output logic              hit_o,
    output logic [15:0]       inst_o,
    output logic [31:0]       data_o,
    output logic              busy_o,
    output logic              err_o,
    output logic [ADDR_W-1:0] wb_adr_o,
    input  logic [15:0]       wb_dat_i,
    output logic [1:0]        wb_sel_o,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    input  logic              wb_ack_i,
    input  logic              wb_err_i
);
    localparam int OFF_W = $clog2(LINE_BYTES);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
    localparam int BEATS = LINE_BYTES / 2;
    localparam int BW    = OFF_W - 1;

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_INVAL} state_t;

    state_t             r_state, w_next;
    logic [15:0]        r_line [LINES][BEATS];
    logic [TAG_W-1:0]   r_tags [LINES];
    logic [LINES-1:0]   r_valid;
    logic [TAG_W-1:0]   r_ftag;
    logic [IDX_W-1:0]   r_fidx;
    logic [BW-1:0]      r_beat;
    logic [IDX_W-1:0]   r_sweep;
    logic               r_inv_pend;
    logic               r_wb_stb;
    logic [ADDR_W-1:0]  r_wb_adr;
    logic               r_err;

    // Lookup works on halfword addresses so the +2/+4 carry wraps mod 2^ADDR_W
    logic [ADDR_W-2:0]  w_h   [3];
    logic [TAG_W-1:0]   w_tag [3];
    logic [IDX_W-1:0]   w_idx [3];
    logic [BW-1:0]      w_off [3];
    logic [2:0]         w_hitk;
    logic               w_allhit;
    logic [TAG_W-1:0]   w_mtag;
    logic [IDX_W-1:0]   w_midx;
    logic               w_last_beat;
    logic               w_last_sweep;
    logic               w_take_ack;

    // Split A, A+2, A+4 into tag/idx/offset and test each against its own line
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            w_h[k]    = adr_i[ADDR_W-1:1] + (ADDR_W-1)'(k);
            w_tag[k]  = w_h[k][ADDR_W-2 -: TAG_W];
            w_idx[k]  = w_h[k][BW +: IDX_W];
            w_off[k]  = w_h[k][BW-1:0];
            w_hitk[k] = r_valid[w_idx[k]] && (r_tags[w_idx[k]] == w_tag[k]);
        end
    end

    assign w_allhit     = &w_hitk;
    assign hit_o        = rst_n_i && (r_state == S_IDLE) && w_allhit;
    assign inst_o       = r_line[w_idx[0]][w_off[0]];
    assign data_o       = {r_line[w_idx[1]][w_off[1]], r_line[w_idx[2]][w_off[2]]};
    assign busy_o       = (r_state != S_IDLE);
    assign err_o        = r_err;
    assign wb_adr_o     = r_wb_adr;
    assign wb_sel_o     = 2'b11;
    assign wb_cyc_o     = r_wb_stb;
    assign wb_stb_o     = r_wb_stb;
    assign w_last_beat  = (r_beat == BW'(BEATS - 1));
    assign w_last_sweep = (r_sweep == IDX_W'(LINES - 1));
    assign w_take_ack   = (r_state == S_FILL) && wb_ack_i && !wb_err_i;

    // Pick the first missing line in address order A, A+2, A+4
    always_comb begin
        w_mtag = w_tag[0];
        w_midx = w_idx[0];
        if (w_hitk[0]) begin
            if (!w_hitk[1]) begin
                w_mtag = w_tag[1];
                w_midx = w_idx[1];
            end else begin
                w_mtag = w_tag[2];
                w_midx = w_idx[2];
            end
        end
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // Next state: invalidation outranks a miss; a fill always runs to completion or error
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (inv_i || r_inv_pend)      w_next = S_INVAL;
                else if (stb_i && !w_allhit)  w_next = S_FILL;
            end
            S_FILL: begin
                if (wb_err_i)                       w_next = S_IDLE;
                else if (wb_ack_i && w_last_beat)   w_next = S_IDLE;
            end
            S_INVAL: begin
                if (w_last_sweep) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Control, valid bits and bus master registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_valid    <= '0;
            r_ftag     <= '0;
            r_fidx     <= '0;
            r_beat     <= '0;
            r_sweep    <= '0;
            r_inv_pend <= 1'b0;
            r_wb_stb   <= 1'b0;
            r_wb_adr   <= '0;
            r_err      <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (inv_i || r_inv_pend) begin
                        r_sweep <= '0;
                    end else if (stb_i && !w_allhit) begin
                        r_ftag          <= w_mtag;
                        r_fidx          <= w_midx;
                        r_valid[w_midx] <= 1'b0;
                        r_wb_adr        <= {w_mtag, w_midx, OFF_W'(0)};
                        r_beat          <= '0;
                        r_wb_stb        <= 1'b1;
                    end
                end
                S_FILL: begin
                    if (inv_i) r_inv_pend <= 1'b1;
                    if (wb_err_i) begin
                        r_wb_stb <= 1'b0;
                        r_err    <= 1'b1;
                    end else if (wb_ack_i) begin
                        r_beat   <= r_beat + BW'(1);
                        r_wb_adr <= r_wb_adr + ADDR_W'(2);
                        if (w_last_beat) begin
                            r_valid[r_fidx] <= 1'b1;
                            r_wb_stb        <= 1'b0;
                        end
                    end
                end
                S_INVAL: begin
                    r_valid[r_sweep] <= 1'b0;
                    r_sweep          <= r_sweep + IDX_W'(1);
                    if (w_last_sweep) r_inv_pend <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Line data and tag storage, written only by accepted fill beats
    always_ff @(posedge clk_i) begin
        if (w_take_ack) begin
            r_line[r_fidx][r_beat] <= wb_dat_i;
            if (w_last_beat) r_tags[r_fidx] <= r_ftag;
        end
    end
endmodule

// File: tb/tb_icache_dm_param.sv
// Self-checking bench for icache_dm_param: a vector table of lookups with
// expected fill addresses and latency, plus hand sequences for invalidate,
// bus error, invalidate-during-fill and asynchronous reset mid-fill.
module tb_icache_dm_param;
    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic [31:0] adr_i;
    logic        stb_i, inv_i;
    logic        hit_o;
    logic [15:0] inst_o;
    logic [31:0] data_o;
    logic        busy_o, err_o;
    logic [31:0] wb_adr_o;
    logic [15:0] wb_dat_i;
    logic [1:0]  wb_sel_o;
    logic        wb_cyc_o, wb_stb_o, wb_ack_i, wb_err_i;

    logic        err_arm;
    logic [31:0] err_adr;
    int          errors = 0;
    int          checks = 0;
    logic [31:0] fill_q[$];
    logic [47:0] exp_q[$];

    typedef struct {
        logic [31:0] adr;
        int          nfill;
        logic [31:0] f0;
        logic [31:0] f1;
        int          lat;
    } vec_t;
    vec_t vecs[9];

    icache_dm_param #(.ADDR_W(32), .LINES(256), .LINE_BYTES(32)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .adr_i(adr_i), .stb_i(stb_i), .inv_i(inv_i),
        .hit_o(hit_o), .inst_o(inst_o), .data_o(data_o), .busy_o(busy_o), .err_o(err_o),
        .wb_adr_o(wb_adr_o), .wb_dat_i(wb_dat_i), .wb_sel_o(wb_sel_o), .wb_cyc_o(wb_cyc_o),
        .wb_stb_o(wb_stb_o), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [15:0] memf(input logic [31:0] a);
        return a[15:0] ^ a[31:16] ^ 16'h5A3C;
    endfunction

    // Zero-wait memory slave with optional error injection at one address
    assign wb_dat_i = memf(wb_adr_o);
    assign wb_err_i = wb_stb_o && err_arm && (wb_adr_o == err_adr);
    assign wb_ack_i = wb_stb_o && !wb_err_i;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push_line(input logic [31:0] base, input int nbeats);
        for (int i = 0; i < nbeats; i++) fill_q.push_back(base + 32'(2 * i));
    endtask

    // Every accepted beat must be the next expected fill address
    always @(negedge clk_i) begin
        if (rst_n_i && wb_stb_o && wb_ack_i) begin
            if (fill_q.size() == 0) check("unexpected_beat", {32'h0, wb_adr_o}, 64'hFFFF_FFFF_FFFF_FFFF);
            else                    check("fill_adr", {32'h0, wb_adr_o}, {32'h0, fill_q.pop_front()});
        end
    end

    task automatic probe(input logic [31:0] a, input logic exp);
        @(negedge clk_i);
        adr_i = a;
        #1 check($sformatf("probe_hit_%0h", a), {63'h0, hit_o}, {63'h0, exp});
    endtask

    task automatic run_vec(input vec_t v);
        int          lat;
        logic [31:0] a;
        a = v.adr & 32'hFFFF_FFFE;
        if (v.nfill >= 1) push_line(v.f0, 16);
        if (v.nfill >= 2) push_line(v.f1, 16);
        exp_q.push_back({memf(a), memf(a + 32'd2), memf(a + 32'd4)});
        @(negedge clk_i);
        adr_i = v.adr;
        stb_i = 1'b1;
        #1 lat = 0;
        while (!hit_o && lat < 200) begin
            @(negedge clk_i);
            #1 lat++;
        end
        check($sformatf("hit_%0h", v.adr), {63'h0, hit_o}, 64'h1);
        check($sformatf("latency_%0h", v.adr), 64'(lat), 64'(v.lat));
        check($sformatf("data_%0h", v.adr), {16'h0, inst_o, data_o}, {16'h0, exp_q.pop_front()});
        stb_i = 1'b0;
        check("fills_done", 64'(fill_q.size()), 64'h0);
        fill_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cnt;
        vecs[0] = '{32'h0000_1000, 1, 32'h0000_1000, 32'h0,         17};
        vecs[1] = '{32'h0000_1000, 0, 32'h0,         32'h0,          0};
        vecs[2] = '{32'h0000_1006, 0, 32'h0,         32'h0,          0};
        vecs[3] = '{32'h0000_101E, 1, 32'h0000_1020, 32'h0,         17};
        vecs[4] = '{32'h0000_1FFC, 2, 32'h0000_1FE0, 32'h0000_2000, 34};
        vecs[5] = '{32'h0000_1FFE, 0, 32'h0,         32'h0,          0};
        vecs[6] = '{32'h0000_0001, 1, 32'h0000_0000, 32'h0,         17};
        vecs[7] = '{32'h0000_1FFC, 1, 32'h0000_2000, 32'h0,         17};
        vecs[8] = '{32'hFFFF_FFFC, 2, 32'hFFFF_FFE0, 32'h0000_0000, 34};

        rst_n_i = 1'b0; adr_i = 32'h0; stb_i = 1'b0; inv_i = 1'b0;
        err_arm = 1'b0; err_adr = 32'h0;
        #1;
        check("rst_hit", {63'h0, hit_o}, 64'h0);
        check("rst_busy", {63'h0, busy_o}, 64'h0);
        check("rst_stb", {63'h0, wb_stb_o}, 64'h0);
        check("rst_adr", {32'h0, wb_adr_o}, 64'h0);
        check("rst_err", {63'h0, err_o}, 64'h0);
        check("sel_const", {62'h0, wb_sel_o}, 64'h3);
        repeat (3) @(negedge clk_i);
        rst_n_i = 1'b1;

        for (int i = 0; i < 9; i++) run_vec(vecs[i]);
        check("cyc_eq_stb", {63'h0, wb_cyc_o}, {63'h0, wb_stb_o});

        // Sweep invalidate: second pulse mid-sweep must be ignored
        probe(32'h0000_1000, 1'b1);
        probe(32'h0000_0000, 1'b1);
        probe(32'hFFFF_FFFC, 1'b1);
        @(negedge clk_i); inv_i = 1'b1;
        @(negedge clk_i); inv_i = 1'b0;
        cnt = 0;
        while (busy_o && cnt < 1000) begin
            cnt++;
            inv_i = (cnt == 10);
            @(negedge clk_i);
        end
        inv_i = 1'b0;
        check("inval_cycles", 64'(cnt), 64'd256);
        probe(32'h0000_1000, 1'b0);
        probe(32'h0000_0000, 1'b0);
        probe(32'hFFFF_FFFC, 1'b0);

        // Bus error on beat 5, then a clean refill
        err_adr = 32'h0000_100A; err_arm = 1'b1;
        push_line(32'h0000_1000, 5);
        @(negedge clk_i); adr_i = 32'h0000_1000; stb_i = 1'b1;
        cnt = 0;
        do begin @(negedge clk_i); cnt++; end while (!err_o && cnt < 100);
        check("err_pulse", {63'h0, err_o}, 64'h1);
        stb_i = 1'b0; err_arm = 1'b0;
        check("err_stb_low", {63'h0, wb_stb_o}, 64'h0);
        check("err_no_hit", {63'h0, hit_o}, 64'h0);
        @(negedge clk_i);
        check("err_single", {63'h0, err_o}, 64'h0);
        check("err_beats", 64'(fill_q.size()), 64'h0);
        fill_q.delete();
        probe(32'h0000_1000, 1'b0);
        run_vec('{32'h0000_1000, 1, 32'h0000_1000, 32'h0, 17});

        // Invalidate requested mid-fill: fill finishes, then a full sweep
        push_line(32'h0000_5000, 16);
        @(negedge clk_i); adr_i = 32'h0000_5000; stb_i = 1'b1;
        cnt = 0;
        while (wb_adr_o != 32'h0000_5008 && cnt < 100) begin @(negedge clk_i); cnt++; end
        inv_i = 1'b1; stb_i = 1'b0;
        @(negedge clk_i); inv_i = 1'b0;
        cnt = 0;
        repeat (600) begin
            @(negedge clk_i);
            #1 if (busy_o && !wb_stb_o) cnt++;
        end
        check("pend_fill_done", 64'(fill_q.size()), 64'h0);
        fill_q.delete();
        check("pend_inval_cycles", 64'(cnt), 64'd256);
        probe(32'h0000_5000, 1'b0);
        probe(32'h0000_1000, 1'b0);

        // Async reset during beat 7 of a fill
        run_vec('{32'h0000_1000, 1, 32'h0000_1000, 32'h0, 17});
        push_line(32'h0000_3000, 7);
        @(negedge clk_i); adr_i = 32'h0000_3000; stb_i = 1'b1;
        cnt = 0;
        while (wb_adr_o != 32'h0000_300C && cnt < 100) begin @(negedge clk_i); cnt++; end
        @(posedge clk_i);
        #1 rst_n_i = 1'b0;
        #1;
        check("rst_mid_stb", {63'h0, wb_stb_o}, 64'h0);
        check("rst_mid_busy", {63'h0, busy_o}, 64'h0);
        check("rst_mid_hit", {63'h0, hit_o}, 64'h0);
        stb_i = 1'b0;
        @(negedge clk_i); rst_n_i = 1'b1;
        check("rst_mid_beats", 64'(fill_q.size()), 64'h0);
        fill_q.delete();
        probe(32'h0000_3000, 1'b0);
        probe(32'h0000_1000, 1'b0);
        probe(32'h0000_0000, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
